// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, forward-select encoding and ID/EX register layout
// Imported by id_ex_operand_stage and operand_fwd_sel.
package pipe_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rs1_addr;
      logic [XLEN-1:0] rs1_data;
      logic [RA_W-1:0] rs2_addr;
      logic [XLEN-1:0] rs2_data;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
   } id_ex_t;

   // True when the retiring write-back targets a real register matching addr.
   function automatic logic wb_hit(input logic we, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] addr);
      return we && (rd != '0) && (rd == addr);
   endfunction

endpackage

// File: rtl/operand_fwd_sel.sv
// rtl/operand_fwd_sel.sv - per-source forward select for one stored EX operand
// x0 always reads zero; EX/MEM beats MEM/WB, otherwise the stored value is used.
module operand_fwd_sel
   import pipe_pkg::*;
#(
   parameter int XLEN = pipe_pkg::XLEN,
   parameter int RA_W = pipe_pkg::RA_W
) (
   input  logic [RA_W-1:0] addr_i,
   input  logic [XLEN-1:0] data_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_reg_write_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_reg_write_i,
   input  logic [XLEN-1:0] wb_result_i,
   output fwd_sel_t        sel_o,
   output logic [XLEN-1:0] value_o
);

   always_comb begin
      sel_o   = SEL_REG;
      value_o = data_i;
      if (addr_i == '0) begin
         value_o = '0;
      end else if (mem_reg_write_i && (mem_rd_i == addr_i)) begin
         sel_o   = SEL_MEM;
         value_o = mem_result_i;
      end else if (wb_reg_write_i && (wb_rd_i == addr_i)) begin
         sel_o   = SEL_WB;
         value_o = wb_result_i;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with operand forwarding and load-use bubble
// Optional FWD_STATS_EN adds saturating forward/bubble counters.
module id_ex_operand_stage
   import pipe_pkg::*;
#(
   parameter int XLEN = pipe_pkg::XLEN,
   parameter int RA_W = pipe_pkg::RA_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            ID_VALID,
   input  logic [RA_W-1:0] ID_RS1_ADDR,
   input  logic [RA_W-1:0] ID_RS2_ADDR,
   input  logic            ID_RS1_USE,
   input  logic            ID_RS2_USE,
   input  logic [XLEN-1:0] ID_RS1_DATA,
   input  logic [XLEN-1:0] ID_RS2_DATA,
   input  logic [RA_W-1:0] ID_RD,
   input  logic            ID_REG_WRITE,
   input  logic            ID_MEM_READ,
   input  logic            STALL,
   input  logic            FLUSH,
   input  logic [RA_W-1:0] MEM_RD,
   input  logic            MEM_REG_WRITE,
   input  logic [XLEN-1:0] MEM_RESULT,
   input  logic [RA_W-1:0] WB_RD,
   input  logic            WB_REG_WRITE,
   input  logic [XLEN-1:0] WB_RESULT,
   output logic            EX_VALID,
   output logic [XLEN-1:0] EX_OP1,
   output logic [XLEN-1:0] EX_OP2,
   output logic [RA_W-1:0] EX_RD,
   output logic            EX_REG_WRITE,
   output logic            EX_MEM_READ,
   output logic            LOAD_USE_STALL
`ifdef FWD_STATS_EN
   ,output logic [31:0]    FWD_MEM_CNT
   ,output logic [31:0]    FWD_WB_CNT
   ,output logic [31:0]    BUBBLE_CNT
`endif
);

   id_ex_t   ex_q, ex_d;
   fwd_sel_t sel1, sel2;
   logic     load_use;

   operand_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .addr_i(ex_q.rs1_addr), .data_i(ex_q.rs1_data),
      .mem_rd_i(MEM_RD), .mem_reg_write_i(MEM_REG_WRITE), .mem_result_i(MEM_RESULT),
      .wb_rd_i(WB_RD), .wb_reg_write_i(WB_REG_WRITE), .wb_result_i(WB_RESULT),
      .sel_o(sel1), .value_o(EX_OP1)
   );

   operand_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .addr_i(ex_q.rs2_addr), .data_i(ex_q.rs2_data),
      .mem_rd_i(MEM_RD), .mem_reg_write_i(MEM_REG_WRITE), .mem_result_i(MEM_RESULT),
      .wb_rd_i(WB_RD), .wb_reg_write_i(WB_REG_WRITE), .wb_result_i(WB_RESULT),
      .sel_o(sel2), .value_o(EX_OP2)
   );

   always_comb begin
      load_use = ID_VALID && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)
              && ((ID_RS1_USE && (ID_RS1_ADDR == ex_q.rd)) ||
                  (ID_RS2_USE && (ID_RS2_ADDR == ex_q.rd)))
              && !FLUSH && !STALL;
   end

   always_comb begin
      ex_d = ex_q;
      if (FLUSH) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
      end else if (STALL) begin
         // Capture WB values now; once WB retires the forward path disappears.
         if (sel1 == SEL_WB) ex_d.rs1_data = WB_RESULT;
         if (sel2 == SEL_WB) ex_d.rs2_data = WB_RESULT;
      end else if (load_use) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
      end else begin
         ex_d.valid     = ID_VALID;
         ex_d.rs1_addr  = ID_RS1_ADDR;
         ex_d.rs2_addr  = ID_RS2_ADDR;
         ex_d.rs1_data  = wb_hit(WB_REG_WRITE, WB_RD, ID_RS1_ADDR) ? WB_RESULT : ID_RS1_DATA;
         ex_d.rs2_data  = wb_hit(WB_REG_WRITE, WB_RD, ID_RS2_ADDR) ? WB_RESULT : ID_RS2_DATA;
         ex_d.rd        = ID_RD;
         ex_d.reg_write = ID_REG_WRITE & ID_VALID;
         ex_d.mem_read  = ID_MEM_READ;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign EX_VALID       = ex_q.valid;
   assign EX_RD          = ex_q.rd;
   assign EX_REG_WRITE   = ex_q.reg_write;
   assign EX_MEM_READ    = ex_q.mem_read;
   assign LOAD_USE_STALL = load_use;

`ifdef FWD_STATS_EN
   logic [31:0] fwd_mem_cnt_q, fwd_wb_cnt_q, bubble_cnt_q;
   logic [1:0]  n_mem, n_wb;

   function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
      logic [32:0] s;
      s = {1'b0, c} + {31'b0, inc};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   assign n_mem = {1'b0, sel1 == SEL_MEM} + {1'b0, sel2 == SEL_MEM};
   assign n_wb  = {1'b0, sel1 == SEL_WB} + {1'b0, sel2 == SEL_WB};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fwd_mem_cnt_q <= '0;
         fwd_wb_cnt_q  <= '0;
         bubble_cnt_q  <= '0;
      end else begin
         if (ex_q.valid && !STALL) begin
            fwd_mem_cnt_q <= sat_add(fwd_mem_cnt_q, n_mem);
            fwd_wb_cnt_q  <= sat_add(fwd_wb_cnt_q, n_wb);
         end
         if (load_use) bubble_cnt_q <= sat_add(bubble_cnt_q, 2'd1);
      end
   end

   assign FWD_MEM_CNT = fwd_mem_cnt_q;
   assign FWD_WB_CNT  = fwd_wb_cnt_q;
   assign BUBBLE_CNT  = bubble_cnt_q;
`endif

endmodule
